// File: rtl/decoder_stream_onehot_pkg.sv
// Shared types and constants for the flow-controlled one-hot decoder.
// The optional error counter is enabled by DECODER_STREAM_ERR_CNT_EN.
package decoder_stream_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
    logic [ERR_CNT_W-1:0] res;
    if (val == {ERR_CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + ERR_CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_stream_onehot_if.sv
// Stream bundle for the one-hot decoder: index input side and decoded output side.
// The slave modport is the decoder; the master modport is the surrounding logic.
interface decoder_stream_onehot_if #(
  parameter int OUT_WIDTH = 8
);
  localparam int IN_WIDTH = $clog2(OUT_WIDTH);

  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_idx;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_onehot;
  logic                 out_err;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_onehot, out_err
  );

  modport master (
    output in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_onehot, out_err
  );

endinterface

// File: rtl/decoder_stream_onehot_decode.sv
// Combinational binary-to-one-hot mapping with out-of-range detection.
// Indices at or above OUT_WIDTH give an all-zero word and err=1.
module onehot_decode #(
  parameter int OUT_WIDTH = 8,
  parameter int IN_WIDTH  = $clog2(OUT_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  idx,
  output logic [OUT_WIDTH-1:0] onehot,
  output logic                 err
);

  // One extra bit so OUT_WIDTH itself is representable for power-of-two widths.
  localparam logic [IN_WIDTH:0] LIMIT = OUT_WIDTH[IN_WIDTH:0];

  for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_bit
    assign onehot[g] = (idx == IN_WIDTH'(g));
  end

  assign err = ({1'b0, idx} >= LIMIT);

endmodule

// File: rtl/decoder_stream_onehot.sv
// Registered one-hot decoder with a two-entry skid buffer (head + skid) on a valid/ready stream.
// Define DECODER_STREAM_ERR_CNT_EN to add the saturating err_cnt output.
module decoder_stream_onehot
  import decoder_stream_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int IN_WIDTH  = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_stream_onehot_if.slave bus
`ifdef DECODER_STREAM_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  typedef struct packed {
    logic                 err;
    logic [OUT_WIDTH-1:0] onehot;
  } entry_t;

  occ_state_t state_r, state_s;
  entry_t     head_r, head_s;
  entry_t     skid_r, skid_s;
  entry_t     dec_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       in_fire_s;
  logic       out_fire_s;

  onehot_decode #(
    .OUT_WIDTH (OUT_WIDTH),
    .IN_WIDTH  (IN_WIDTH)
  ) u_decode (
    .idx    (bus.in_idx),
    .onehot (dec_s.onehot),
    .err    (dec_s.err)
  );

  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;

  // Occupancy next-state and buffer movement.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    skid_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          head_s  = dec_s;
          state_s = ONE;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        case ({in_fire_s, out_fire_s})
          2'b10: begin
            skid_s  = dec_s;
            state_s = TWO;
          end
          2'b01: state_s = EMPTY;
          2'b11: head_s  = dec_s;
          default: state_s = ONE;
        endcase
      end
      TWO: begin
        if (out_fire_s) begin
          head_s  = skid_r;
          state_s = ONE;
        end else begin
          state_s = TWO;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State, buffer and handshake-flag registers; flags come from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      head_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      head_r      <= head_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != TWO);
      out_valid_r <= (state_s != EMPTY);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_onehot = head_r.onehot;
  assign bus.out_err    = head_r.err;

`ifdef DECODER_STREAM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Errors are counted as they leave, so stalled words are not yet counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (out_fire_s && head_r.err) begin
      err_cnt_r <= sat_inc(err_cnt_r);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_decoder_stream_onehot.sv
// Drives an OUT_WIDTH=8 and an OUT_WIDTH=6 decoder in lockstep from shared stimulus,
// checking directed tables, reset corners and random traffic against a queue model.
`timescale 1ns/1ps
module tb_decoder_stream_onehot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_idx = 3'd0;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_stream_onehot_if #(.OUT_WIDTH(8)) bus8();
  decoder_stream_onehot_if #(.OUT_WIDTH(6)) bus6();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_idx    = in_idx;
  assign bus8.out_ready = out_ready;
  assign bus6.in_valid  = in_valid;
  assign bus6.in_idx    = in_idx;
  assign bus6.out_ready = out_ready;

`ifdef DECODER_STREAM_ERR_CNT_EN
  logic [7:0] err_cnt8;
  logic [7:0] err_cnt6;
  decoder_stream_onehot #(.OUT_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .err_cnt(err_cnt8));
  decoder_stream_onehot #(.OUT_WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6), .err_cnt(err_cnt6));
`else
  decoder_stream_onehot #(.OUT_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  decoder_stream_onehot #(.OUT_WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
`endif

  // Reference model: FIFO of accepted indices (capacity 2) plus per-width error counts.
  int q[$];
  int cnt8 = 0;
  int cnt6 = 0;

  function automatic logic [7:0] exp_oh(input int idx, input int w);
    return (idx < w) ? (8'd1 << idx) : 8'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("in_ready8", 32'(bus8.in_ready), 32'(q.size() < 2));
    chk("in_ready6", 32'(bus6.in_ready), 32'(q.size() < 2));
    chk("out_valid8", 32'(bus8.out_valid), 32'(q.size() > 0));
    chk("out_valid6", 32'(bus6.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("onehot8", 32'(bus8.out_onehot), 32'(exp_oh(q[0], 8)));
      chk("err8", 32'(bus8.out_err), 32'(q[0] >= 8));
      chk("onehot6", 32'(bus6.out_onehot), 32'(exp_oh(q[0], 6)));
      chk("err6", 32'(bus6.out_err), 32'(q[0] >= 6));
    end
`ifdef DECODER_STREAM_ERR_CNT_EN
    chk("err_cnt8", 32'(err_cnt8), 32'(cnt8));
    chk("err_cnt6", 32'(err_cnt6), 32'(cnt6));
`endif
  endtask

  // One clock: drive, advance the model on the edge, then compare just after it.
  task automatic step(input logic v, input logic [2:0] idx, input logic ordy);
    logic in_f;
    logic out_f;
    in_valid  = v;
    in_idx    = idx;
    out_ready = ordy;
    in_f  = v && (q.size() < 2);
    out_f = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (out_f) begin
      if (q[0] >= 6 && cnt6 < 255) cnt6++;
      if (q[0] >= 8 && cnt8 < 255) cnt8++;
      void'(q.pop_front());
    end
    if (in_f) q.push_back(int'(idx));
    chk_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready8"}, 32'(bus8.in_ready), 32'd1);
    chk({tag, "_in_ready6"}, 32'(bus6.in_ready), 32'd1);
    chk({tag, "_out_valid8"}, 32'(bus8.out_valid), 32'd0);
    chk({tag, "_out_valid6"}, 32'(bus6.out_valid), 32'd0);
    chk({tag, "_onehot8"}, 32'(bus8.out_onehot), 32'd0);
    chk({tag, "_onehot6"}, 32'(bus6.out_onehot), 32'd0);
    chk({tag, "_err8"}, 32'(bus8.out_err), 32'd0);
    chk({tag, "_err6"}, 32'(bus6.out_err), 32'd0);
`ifdef DECODER_STREAM_ERR_CNT_EN
    chk({tag, "_err_cnt8"}, 32'(err_cnt8), 32'd0);
    chk({tag, "_err_cnt6"}, 32'(err_cnt6), 32'd0);
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges; entered and left at posedge+1.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    in_valid  = 1'b1;
    in_idx    = 3'd2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    q.delete();
    cnt8 = 0;
    cnt6 = 0;
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit       rst;
    bit       v;
    bit [2:0] idx;
    bit       ordy;
    bit       rdy;
    bit       ov;
    bit [7:0] oh8;
    bit       e8;
    bit [7:0] oh6;
    bit       e6;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Streaming 0..7 with out_ready high: each word visible one cycle after acceptance.
    tbl.push_back('{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'h08, 1'b0, 8'h08, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    // Stall on 3,5 (6 refused), then release with a simultaneous in/out transfer.
    tbl.push_back('{1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 8'h08, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 8'h08, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 8'h08, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    // Out-of-range 6 and 7 on the narrow instance, from a fresh reset.
    tbl.push_back('{1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("idle");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) mid_reset();
      step(tbl[i].v, tbl[i].idx, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus8.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus8.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_onehot8", i), 32'(bus8.out_onehot), 32'(tbl[i].oh8));
        chk($sformatf("tbl%0d_err8", i), 32'(bus8.out_err), 32'(tbl[i].e8));
        chk($sformatf("tbl%0d_onehot6", i), 32'(bus6.out_onehot), 32'(tbl[i].oh6));
        chk($sformatf("tbl%0d_err6", i), 32'(bus6.out_err), 32'(tbl[i].e6));
      end
    end
`ifdef DECODER_STREAM_ERR_CNT_EN
    chk("oor_err_cnt6", 32'(err_cnt6), 32'd2);
    chk("oor_err_cnt8", 32'(err_cnt8), 32'd0);
`endif

    // Fill to TWO, reset between edges, then check the first post-reset word.
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    chk("two_in_ready", 32'(bus8.in_ready), 32'd0);
    mid_reset();
    step(1'b1, 3'd4, 1'b0);
    chk("post_rst_onehot8", 32'(bus8.out_onehot), 32'h10);
    chk("post_rst_onehot6", 32'(bus6.out_onehot), 32'h10);
    step(1'b0, 3'd0, 1'b1);
    chk("post_rst_drained", 32'(bus8.out_valid), 32'd0);

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_stream_onehot.md
# decoder_stream_onehot

Registered, flow-controlled binary-to-one-hot decoder. It is the receive-side counterpart of the priority/parameterised encoders: it accepts an index plus valid bit from an encoder-fed stream and emits a one-hot word. Full-throughput valid/ready handshakes are used on both sides, with a two-entry skid buffer so that `in_ready` is a pure register output. An out-of-range index produces an all-zero word with an error flag.

## Interface
- `OUT_WIDTH`, 8 — one-hot output width; any value ≥ 2, not necessarily a power of two.
- `IN_WIDTH`, `$clog2(OUT_WIDTH)` — index width; do not override.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `in_valid` input 1 — index word offered.
- `in_idx` input IN_WIDTH — binary index to decode.
- `in_ready` output 1 — block can accept; registered.
- `out_valid` output 1 — decoded word available.
- `out_onehot` output OUT_WIDTH — bit `in_idx` set; all zero when the index is out of range.
- `out_err` output 1 — the presented word came from an index ≥ OUT_WIDTH.
- `out_ready` input 1 — downstream accepts.
- `err_cnt` output 8 — present only with `DECODER_STREAM_ERR_CNT_EN`.

## Operation
- **Transfers:**
  - Input transfer when `in_valid & in_ready` at a rising edge.
  - Output transfer when `out_valid & out_ready` at a rising edge.
- **Decoding:**
  - Each entry is decoded at capture and stored as {onehot, err}; the index itself is not stored.
  - `idx < OUT_WIDTH`: onehot = `1 << idx`, err = 0.
  - `idx ≥ OUT_WIDTH`: onehot = 0, err = 1. This case only exists for non-power-of-two OUT_WIDTH.
- **FSM on occupancy:** EMPTY, ONE, TWO. The output register is the head entry; the skid register holds the second entry.
  - EMPTY: an input transfer goes to ONE.
  - ONE, input only: go to TWO.
  - ONE, output only: go to EMPTY.
  - ONE, input and output together: stay in ONE; the head is replaced by the new word.
  - TWO, output transfer: the skid entry moves to the head and the state goes to ONE. No input is possible in TWO.
- **Flags:**
  - `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is computed from the next state and registered.
  - `out_valid` = 1 in ONE and TWO.
- **Stability:** while `out_valid=1 & out_ready=0`, `out_onehot` and `out_err` hold stable.
- **Ordering:** words are never dropped, duplicated or reordered.
- `in_idx` is ignored when `in_valid=0`. `out_ready` may be asserted with `out_valid=0` without effect.

## Timing
- **Reset:** state EMPTY, `in_ready=1`, `out_valid=0`, `out_onehot=0`, `out_err=0`, `err_cnt=0`.
- **Reset mid-operation:** buffered entries are discarded, and `rst_n` low forces the reset values immediately. `in_ready` first rises with the `rst_n` assertion (reset value); no transfer occurs while `rst_n` is low.
- **Latency:** 1 cycle. An input accepted at edge N appears with `out_valid=1` after edge N.
- **Throughput:** 1 word/cycle with `out_ready` held high.
- **Stall:** with `out_ready=0`, two words are accepted, then `in_ready=0` from the cycle after the second acceptance.
- **Release:** after a stall, `in_ready` returns to 1 one cycle after the first output transfer.
- There are no combinational paths from inputs to outputs.

## Configuration
- `DECODER_STREAM_ERR_CNT_EN` defined:
  - Adds the `err_cnt` port, an 8-bit saturating count of output transfers with `out_err=1`.
  - The count sticks at 255 and clears only on reset.
  - Counting happens on output transfer, not on input, so a word stalled in the buffer is not yet counted.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- **Package `decoder_stream_pkg`:**
  - State enum `occ_state_t` {EMPTY, ONE, TWO}.
  - `ERR_CNT_W = 8` localparam.
  - Entry struct packing {err, onehot} is parameter-dependent, so it is built in the module.
- **Sub-module `onehot_decode`:**
  - Combinational, parameterised by OUT_WIDTH.
  - Maps `idx` to {onehot, err}.
  - Instantiated once, at the input side.

## Test plan
- **Reset values:** reset, then idle -> all outputs at reset values; `in_ready=1`.
- **Streaming:** OUT_WIDTH=8, `out_ready=1`, indices 0..7 back-to-back -> `out_onehot` 0x01,0x02,…,0x80 on consecutive cycles, each one cycle after acceptance; `out_err=0` throughout.
- **Stall and release:** `out_ready=0`, offer idx 3,5,6 -> 3 and 5 accepted, `in_ready=0`, output holds 0x08. Raise `out_ready` -> outputs 0x08, 0x20, then 0x40 after 6 is accepted.
- **Out-of-range index:** OUT_WIDTH=6, offer idx 6 then 7 -> `out_onehot=0`, `out_err=1` for both. With the macro defined, `err_cnt` reads 2.
- **Simultaneous transfers:** ONE state, `in_valid` and `out_ready` both high -> head replaced in the same edge, state stays ONE; no word lost.
- **Reset mid-operation:** TWO state, pulse `rst_n` low mid-cycle -> outputs zero immediately, buffered words discarded; after release the first new input decodes correctly.
